// File: rtl/multi_channel_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_sync_debounce
// Description : Brings CHANNELS asynchronous inputs into the FAST_CLOCK domain
//               through a SYNC_STAGES-deep flop chain per channel, then filters
//               each synchronised bit with a debounce counter. A change on a
//               channel is accepted only after DEBOUNCE_CYCLES consecutive
//               differing samples. Registered one-cycle rise/fall pulses
//               accompany each accepted change. ENABLE=0 freezes the outputs
//               and clears the counters.
// Ports       : FAST_CLOCK  in  1         system clock, rising edge
//               RESET_N     in  1         asynchronous active-low reset
//               INPUT_DATA  in  CHANNELS  raw asynchronous inputs
//               ENABLE      in  1         1 = debounce active, 0 = hold
//               OUTPUT_DATA out CHANNELS  debounced level per channel
//               RISE_PULSE  out CHANNELS  1-cycle pulse on OUTPUT_DATA 0->1
//               FALL_PULSE  out CHANNELS  1-cycle pulse on OUTPUT_DATA 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_sync_debounce #(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_LEVEL     = 1
) (
  input  logic                FAST_CLOCK,
  input  logic                RESET_N,
  input  logic [CHANNELS-1:0] INPUT_DATA,
  input  logic                ENABLE,
  output logic [CHANNELS-1:0] OUTPUT_DATA,
  output logic [CHANNELS-1:0] RISE_PULSE,
  output logic [CHANNELS-1:0] FALL_PULSE
);

  // Counter must hold values up to DEBOUNCE_CYCLES-1; keep at least one bit
  // so the DEBOUNCE_CYCLES=1 case still has a legal vector.
  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            RST_LVL = (RESET_LEVEL != 0);

  logic [SYNC_STAGES-1:0] sync_chain [CHANNELS];
  logic [CNT_W-1:0]       cnt        [CHANNELS];
  logic [CHANNELS-1:0]    synced;

  // Synchroniser: runs every cycle independent of ENABLE. Bit 0 is the
  // capture flop; the top bit is the synchronised sample.
  always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_chain[i] <= {SYNC_STAGES{RST_LVL}};
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], INPUT_DATA[i]};
      end
    end
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync_tap
      assign synced[g] = sync_chain[g][SYNC_STAGES-1];
    end
  endgenerate

  // Debounce: per channel, count consecutive samples that differ from the
  // current output. Any sample that agrees with the output clears the count,
  // so short glitches and fast toggling never commit.
  always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      OUTPUT_DATA <= {CHANNELS{RST_LVL}};
      RISE_PULSE  <= '0;
      FALL_PULSE  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      RISE_PULSE <= '0;
      FALL_PULSE <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!ENABLE) begin
          cnt[i] <= '0;
        end else if (synced[i] == OUTPUT_DATA[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          // Commit: the pulse is registered alongside the level change so
          // both become visible in the same cycle.
          OUTPUT_DATA[i] <= synced[i];
          RISE_PULSE[i]  <= synced[i];
          FALL_PULSE[i]  <= ~synced[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_channel_sync_debounce
// Description : Directed self-checking bench for multi_channel_sync_debounce
//               with default parameters (2 channels, 2 sync stages,
//               4-cycle debounce, reset level 1). Expected output samples are
//               queued as each step is driven and consumed one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_sync_debounce;

  localparam int LAT = 6; // SYNC_STAGES + DEBOUNCE_CYCLES

  logic       clk;
  logic       rst_n;
  logic [1:0] in_data;
  logic       enable;
  logic [1:0] out_data;
  logic [1:0] rise;
  logic [1:0] fall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  exp_t sb[$];

  multi_channel_sync_debounce #(
    .CHANNELS       (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .RESET_LEVEL    (1)
  ) dut (
    .FAST_CLOCK (clk),
    .RESET_N    (rst_n),
    .INPUT_DATA (in_data),
    .ENABLE     (enable),
    .OUTPUT_DATA(out_data),
    .RISE_PULSE (rise),
    .FALL_PULSE (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [1:0] o, input logic [1:0] r, input logic [1:0] f);
    exp_t e;
    e.tag  = tag;
    e.out  = o;
    e.rise = r;
    e.fall = f;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      total++;
      assert (out_data === e.out) else begin
        bad++;
        $error("FAIL %s out observed=%b expected=%b", e.tag, out_data, e.out);
      end
      total++;
      assert (rise === e.rise) else begin
        bad++;
        $error("FAIL %s rise observed=%b expected=%b", e.tag, rise, e.rise);
      end
      total++;
      assert (fall === e.fall) else begin
        bad++;
        $error("FAIL %s fall observed=%b expected=%b", e.tag, fall, e.fall);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic hold(input string tag, input logic [1:0] o, input int n);
    for (int k = 1; k <= n; k++) push($sformatf("%s[%0d]", tag, k), o, 2'b00, 2'b00);
    for (int k = 1; k <= n; k++) tick();
  endtask

  // Input already changed just before the next edge: output moves from prev
  // to nxt at edge LAT with the matching pulses, for that cycle only.
  task automatic expect_commit(input string tag, input logic [1:0] prev, input logic [1:0] nxt, input int n);
    for (int k = 1; k <= n; k++) begin
      if (k < LAT)       push($sformatf("%s[%0d]", tag, k), prev, 2'b00, 2'b00);
      else if (k == LAT) push($sformatf("%s[%0d]", tag, k), nxt, nxt & ~prev, prev & ~nxt);
      else               push($sformatf("%s[%0d]", tag, k), nxt, 2'b00, 2'b00);
    end
    for (int k = 1; k <= n; k++) tick();
  endtask

  initial begin
    rst_n   = 1'b1;
    in_data = 2'b00;
    enable  = 1'b1;
    @(posedge clk);
    #1;

    // 1. Asynchronous reset, checked before any clock edge
    rst_n = 1'b0;
    #1;
    push("reset_async", 2'b11, 2'b00, 2'b00);
    check_now();
    hold("reset_hold", 2'b11, 2);
    in_data = 2'b11;
    rst_n   = 1'b1;
    hold("reset_exit", 2'b11, 4);

    // 2. Clean fall on ch0
    in_data = 2'b10;
    expect_commit("fall_ch0", 2'b11, 2'b10, 8);

    // 3. Glitch reject on ch1 (3 low cycles), then 4-cycle low commits
    in_data = 2'b00;
    hold("glitch_low", 2'b10, 3);
    in_data = 2'b10;
    hold("glitch_after", 2'b10, 8);
    in_data = 2'b00;
    expect_commit("fall_ch1", 2'b10, 2'b00, 8);

    // 4. Simultaneous edges on both channels, then a single rise
    in_data = 2'b11;
    expect_commit("rise_both", 2'b00, 2'b11, 8);
    in_data = 2'b00;
    expect_commit("fall_both", 2'b11, 2'b00, 8);
    in_data = 2'b01;
    expect_commit("rise_ch0", 2'b00, 2'b01, 8);

    // 5. ENABLE low holds the output; commit 4 edges after re-enable
    in_data = 2'b00;
    enable  = 1'b0;
    hold("disabled", 2'b01, 10);
    enable = 1'b1;
    push("reen[1]", 2'b01, 2'b00, 2'b00);
    push("reen[2]", 2'b01, 2'b00, 2'b00);
    push("reen[3]", 2'b01, 2'b00, 2'b00);
    push("reen[4]", 2'b00, 2'b00, 2'b01);
    push("reen[5]", 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++) tick();

    // 6. Reset in the middle of a pending count on ch0
    in_data = 2'b11;
    expect_commit("restore", 2'b00, 2'b11, 8);
    in_data = 2'b10;
    hold("pending", 2'b11, 4);
    rst_n = 1'b0;
    #1;
    push("mid_reset", 2'b11, 2'b00, 2'b00);
    check_now();
    hold("mid_reset_hold", 2'b11, 1);
    rst_n = 1'b1;
    expect_commit("post_reset", 2'b11, 2'b10, 8);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
